// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer
//    Multi-cycle control/execute sequencer for the 8-bit lab CPU. It drives the
//    initiator side of the 8x8 register file. One 32-bit instruction is accepted
//    per INSTR_VALID/INSTR_READY handshake. The sequencer reads two operands,
//    computes an 8-bit result and issues a single-cycle write-back.
//
//    Instruction word: [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2/imm.
//    Only the low ADDR_W bits of each register field are used.
//    Opcodes: 00 loadi, 01 mov, 02 add, 03 sub, 04 and, 05 or. All others are illegal.
//
//    Ports:
//       CLK, RESET               clock and synchronous active-high reset
//       INSTR, INSTR_VALID       instruction input and its valid strobe
//       INSTR_READY              sequencer is idle and can accept an instruction
//       RF_ADDR_A/B, RF_OUT_A/B  register file read addresses and read data
//                                (the read data arrives one cycle after the address)
//       RF_ADDR_IN, RF_IN        register file write address and write data
//       RF_WRITE_EN              one-cycle write pulse per retired instruction
//       BUSY                     high whenever the FSM is not in IDLE
//       RETIRE_CNT               wrapping count of written-back instructions
//       ILLEGAL                  sticky illegal-opcode trap flag
//
//    Build option: define ILLEGAL_TRAP_EN to enable the trap. When it is set, an
//    illegal opcode sets ILLEGAL in its WB cycle. The FSM then halts in IDLE with
//    INSTR_READY low until RESET. Without the macro, ILLEGAL is tied low and
//    illegal opcodes retire as NOPs.
module reg_op_sequencer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [31:0]       INSTR,
   input  logic              INSTR_VALID,
   output logic              INSTR_READY,
   output logic [ADDR_W-1:0] RF_ADDR_A,
   output logic [ADDR_W-1:0] RF_ADDR_B,
   input  logic [DATA_W-1:0] RF_OUT_A,
   input  logic [DATA_W-1:0] RF_OUT_B,
   output logic [ADDR_W-1:0] RF_ADDR_IN,
   output logic [DATA_W-1:0] RF_IN,
   output logic              RF_WRITE_EN,
   output logic              BUSY,
   output logic [CNT_W-1:0]  RETIRE_CNT,
   output logic              ILLEGAL
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_EXEC = 2'd2;
   localparam logic [1:0] S_WB   = 2'd3;

   logic [1:0]        r_state;
   logic [7:0]        r_op;
   logic [ADDR_W-1:0] r_dest;
   logic [DATA_W-1:0] r_imm;
   logic [ADDR_W-1:0] r_addr_a;
   logic [ADDR_W-1:0] r_addr_b;
   logic [ADDR_W-1:0] r_addr_in;
   logic [DATA_W-1:0] r_rf_in;
   logic              r_we;
   logic              r_ready;
   logic              r_busy;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_legal;
   logic              w_trap;
   logic [DATA_W-1:0] w_result;
   logic              w_unused;

   // The upper bits of the register fields are ignored.
   assign w_unused = ^{INSTR[23:16+ADDR_W], INSTR[15:8+ADDR_W]};

   assign w_legal = (r_op <= 8'h05);

`ifdef ILLEGAL_TRAP_EN
   logic r_illegal;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_illegal <= 1'b0;
      end else if (r_state == S_EXEC && !w_legal) begin
         r_illegal <= 1'b1;
      end
   end

   assign w_trap = r_illegal;
`else
   assign w_trap = 1'b0;
`endif

   always_comb begin
      w_result = '0;
      case (r_op)
         8'h00:   w_result = r_imm;
         8'h01:   w_result = RF_OUT_A;
         8'h02:   w_result = RF_OUT_A + RF_OUT_B;
         8'h03:   w_result = RF_OUT_A - RF_OUT_B;
         8'h04:   w_result = RF_OUT_A & RF_OUT_B;
         8'h05:   w_result = RF_OUT_A | RF_OUT_B;
         default: w_result = '0;
      endcase
   end

   // The read addresses are registered on the handshake edge, so they are valid
   // throughout READ. The register file answers during EXEC, and the write-back
   // registers are loaded on the EXEC->WB edge. RF_WRITE_EN is therefore high
   // for exactly the WB cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state   <= S_IDLE;
         r_op      <= '0;
         r_dest    <= '0;
         r_imm     <= '0;
         r_addr_a  <= '0;
         r_addr_b  <= '0;
         r_addr_in <= '0;
         r_rf_in   <= '0;
         r_we      <= 1'b0;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // r_ready is held low while trapped, which blocks acceptance.
               if (INSTR_VALID && r_ready) begin
                  r_op     <= INSTR[31:24];
                  r_dest   <= INSTR[16 +: ADDR_W];
                  r_imm    <= DATA_W'(INSTR[7:0]);
                  r_addr_a <= INSTR[8 +: ADDR_W];
                  r_addr_b <= INSTR[0 +: ADDR_W];
                  r_ready  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= S_READ;
               end
            end
            S_READ: begin
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               r_addr_in <= r_dest;
               r_rf_in   <= w_result;
               if (w_legal) begin
                  r_we  <= 1'b1;
                  r_cnt <= r_cnt + 1'b1;
               end
               r_state <= S_WB;
            end
            default: begin
               r_busy  <= 1'b0;
               r_ready <= !w_trap;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign INSTR_READY = r_ready;
   assign RF_ADDR_A   = r_addr_a;
   assign RF_ADDR_B   = r_addr_b;
   assign RF_ADDR_IN  = r_addr_in;
   assign RF_IN       = r_rf_in;
   assign RF_WRITE_EN = r_we;
   assign BUSY        = r_busy;
   assign RETIRE_CNT  = r_cnt;
   assign ILLEGAL     = w_trap;

endmodule
